// File: rtl/pe_seq.sv
// Sequencer that feeds a single multiply-accumulate PE to compute C = A x B for 3x3 8-bit matrices.
// Optional build macro PE_SEQ_ZERO_SKIP_EN gates the accumulate enable on zero operands.
module pe_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  input  logic       ld_sel,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       en_reg_Acc,
  output logic       acc_clr,
  input  logic [7:0] y_in,
  output logic       res_valid,
  output logic [3:0] res_idx,
  output logic [7:0] res_data
);

  typedef enum logic [2:0] {IDLE, CLR, MAC, WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] i, j, k;
  logic [7:0] a_mem [0:8];
  logic [7:0] b_mem [0:8];

  logic [1:0] k_fetch;
  logic [7:0] a_fetch, b_fetch;
  logic       mac_en;

  function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] r4;
    r4 = {2'b00, r};
    return r4 * 4'd3 + {2'b00, c};
  endfunction

  assign ld_ready = !busy;
  assign res_data = res_valid ? y_in : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 9; e++) begin
        a_mem[e] <= 8'd0;
        b_mem[e] <= 8'd0;
      end
    end else if (ld_valid && ld_ready && ld_addr <= 4'd8) begin
      if (ld_sel)
        b_mem[ld_addr] <= ld_data;
      else
        a_mem[ld_addr] <= ld_data;
    end
  end

  // Operands for the MAC step about to be entered: k=0 from CLR, k+1 from MAC.
  always_comb begin
    k_fetch = 2'd0;
    if (state == MAC && k != 2'd2)
      k_fetch = k + 2'd1;
    a_fetch = a_mem[idx(i, k_fetch)];
    b_fetch = b_mem[idx(k_fetch, j)];
`ifdef PE_SEQ_ZERO_SKIP_EN
    mac_en = (a_fetch != 8'd0) && (b_fetch != 8'd0);
`else
    mac_en = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      i          <= 2'd0;
      j          <= 2'd0;
      k          <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_out      <= 8'd0;
      b_out      <= 8'd0;
      en_reg_Acc <= 1'b0;
      acc_clr    <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= 4'd0;
    end else begin
      done       <= 1'b0;
      a_out      <= 8'd0;
      b_out      <= 8'd0;
      en_reg_Acc <= 1'b0;
      acc_clr    <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= 4'd0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLR;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
            i       <= 2'd0;
            j       <= 2'd0;
            k       <= 2'd0;
          end
        end
        CLR: begin
          state      <= MAC;
          k          <= 2'd0;
          a_out      <= a_fetch;
          b_out      <= b_fetch;
          en_reg_Acc <= mac_en;
        end
        MAC: begin
          if (k == 2'd2) begin
            state     <= WAIT;
            k         <= 2'd0;
            res_valid <= 1'b1;
            res_idx   <= idx(i, j);
          end else begin
            k          <= k + 2'd1;
            a_out      <= a_fetch;
            b_out      <= b_fetch;
            en_reg_Acc <= mac_en;
          end
        end
        WAIT: begin
          // Row-major walk over C; the last element hands over to DONE.
          if (i == 2'd2 && j == 2'd2) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            i     <= 2'd0;
            j     <= 2'd0;
          end else begin
            state   <= CLR;
            acc_clr <= 1'b1;
            if (j == 2'd2) begin
              j <= 2'd0;
              i <= i + 2'd1;
            end else begin
              j <= j + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq.sv
// Directed bench for pe_seq with a behavioural PE (one-cycle registered accumulator) closing the loop.
module tb_pe_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid, ld_sel;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       start;
  logic       busy, done;
  logic [7:0] a_out, b_out;
  logic       en_reg_Acc, acc_clr;
  logic [7:0] y_in;
  logic       res_valid;
  logic [3:0] res_idx;
  logic [7:0] res_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0][7:0] a;
    logic [8:0][7:0] b;
    logic [8:0][7:0] exp;
    logic [5:0]      enExp;
  } vec_t;

  vec_t vecs [0:3];

  always #5 clk = ~clk;

  pe_seq dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .start(start), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .en_reg_Acc(en_reg_Acc), .acc_clr(acc_clr),
    .y_in(y_in), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
  );

  // Behavioural PE: clear or accumulate a*b modulo 256, result visible the cycle after.
  logic [7:0] acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= 8'd0;
    else if (acc_clr)
      acc <= 8'd0;
    else if (en_reg_Acc)
      acc <= acc + a_out * b_out;
  end
  assign y_in = acc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic loadVec(input vec_t v);
    for (int e = 0; e < 9; e++) applyStimulus(1'b0, 4'(e), v.a[e]);
    for (int e = 0; e < 9; e++) applyStimulus(1'b1, 4'(e), v.b[e]);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " ld_ready"}, int'(ld_ready), 1);
    checkOutput({tag, " a_out"}, int'(a_out), 0);
    checkOutput({tag, " b_out"}, int'(b_out), 0);
    checkOutput({tag, " en_reg_Acc"}, int'(en_reg_Acc), 0);
    checkOutput({tag, " acc_clr"}, int'(acc_clr), 0);
    checkOutput({tag, " res_valid"}, int'(res_valid), 0);
    checkOutput({tag, " res_idx"}, int'(res_idx), 0);
    checkOutput({tag, " res_data"}, int'(res_data), 0);
  endtask

  // Runs one multiply; pokeAt > 0 attempts an A[0]=0xFF write at that busy cycle.
  task automatic runMatrix(input vec_t v, input string tag, input int pokeAt);
    int cyc = 1, got = 0, enCnt = 0, busyCnt = 0, doneCyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc <= 80 && doneCyc == 0) begin
      if (res_valid) begin
        if (got < 9) begin
          checkOutput($sformatf("%s res_idx #%0d", tag, got), int'(res_idx), got);
          checkOutput($sformatf("%s res_data #%0d", tag, got), int'(res_data), int'(v.exp[got]));
        end
        got++;
      end
      if (cyc == 2) checkOutput({tag, " first a_out"}, int'(a_out), int'(v.a[0]));
      if (en_reg_Acc) enCnt++;
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = cyc;
        start = 1'b1;
      end
      if (cyc == pokeAt) begin
        checkOutput({tag, " ld_ready while busy"}, int'(ld_ready), 0);
        applyStimulus(1'b0, 4'd0, 8'hFF);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    start = 1'b0;
    checkOutput({tag, " done cycle"}, doneCyc, 46);
    checkOutput({tag, " busy cycles"}, busyCnt, 45);
    checkOutput({tag, " results"}, got, 9);
    checkOutput({tag, " en cycles"}, enCnt, int'(v.enExp));
    checkOutput({tag, " start in DONE ignored"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({tag, " still idle"}, int'(busy), 0);
  endtask

  initial begin
    int busyCnt;
    bit sawDone;
    rst = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'd0; start = 1'b0;

`ifdef PE_SEQ_ZERO_SKIP_EN
    vecs[0].enExp = 6'd9;  vecs[1].enExp = 6'd27; vecs[2].enExp = 6'd27; vecs[3].enExp = 6'd0;
`else
    vecs[0].enExp = 6'd27; vecs[1].enExp = 6'd27; vecs[2].enExp = 6'd27; vecs[3].enExp = 6'd27;
`endif
    for (int e = 0; e < 9; e++) begin
      vecs[0].a[e] = 8'(e + 1);
      vecs[0].b[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
      vecs[1].a[e] = 8'(e + 1);
      vecs[1].b[e] = 8'd1;
      vecs[2].a[e] = 8'd16;
      vecs[2].b[e] = 8'd16;
      vecs[3].a[e] = 8'd0;
      vecs[3].b[e] = 8'd0;
    end
    vecs[0].exp = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[1].exp = {8'd24, 8'd24, 8'd24, 8'd15, 8'd15, 8'd15, 8'd6, 8'd6, 8'd6};
    vecs[2].exp = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[3].exp = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      loadVec(vecs[t]);
      runMatrix(vecs[t], $sformatf("vec%0d", t), 0);
    end

    $display("[TB] write while busy and out-of-range address");
    loadVec(vecs[0]);
    runMatrix(vecs[0], "busy write", 7);
    runMatrix(vecs[0], "after busy write", 0);
    applyStimulus(1'b0, 4'd12, 8'hFF);
    applyStimulus(1'b1, 4'd12, 8'hFF);
    runMatrix(vecs[0], "after addr 12", 0);

    $display("[TB] reset in the middle of a run");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCnt = 0;
    for (int c = 0; c < 60 && busyCnt < 20; c++) begin
      if (busy) busyCnt++;
      if (busyCnt < 20) @(negedge clk);
    end
    checkOutput("reached busy cycle 20", busyCnt, 20);
    rst = 1'b1;
    #1;
    checkIdleOutputs("mid-run reset");
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("no done after reset", int'(sawDone), 0);
    runMatrix(vecs[3], "cleared regs", 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
